mem_ls: RTL and testbench

Load/store MEM stage for SammingCPU. It replaces the pass-through MEM stage and sits between the EX/MEM and MEM/WB pipeline registers. It issues byte/halfword/word accesses to the data RAM over a req/ack handshake, aligns and extends load data, and stalls the pipeline while a RAM access is outstanding. Its outputs to WB are registered, and it aborts any access that exceeds a wait-state limit.

---
 rtl/mem_ls_pkg.sv | 42 ++++
 rtl/mem_align.sv | 78 +++++++
 rtl/mem_ls.sv | 157 +++++++++++++++
 tb/tb_mem_ls.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ls_pkg.sv
// Shared definitions for the SammingCPU load/store MEM stage:
// memop codes, byte-enable patterns, reset/write constants and FSM states.
package mem_ls_pkg;

    localparam int MEM_OP_W = 4;

    localparam logic [MEM_OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [MEM_OP_W-1:0] OP_LB  = 4'd1;
    localparam logic [MEM_OP_W-1:0] OP_LBU = 4'd2;
    localparam logic [MEM_OP_W-1:0] OP_LH  = 4'd3;
    localparam logic [MEM_OP_W-1:0] OP_LHU = 4'd4;
    localparam logic [MEM_OP_W-1:0] OP_LW  = 4'd5;
    localparam logic [MEM_OP_W-1:0] OP_SB  = 4'd6;
    localparam logic [MEM_OP_W-1:0] OP_SH  = 4'd7;
    localparam logic [MEM_OP_W-1:0] OP_SW  = 4'd8;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_LANE0   = 4'b1000;
    localparam logic [3:0] SEL_HI_HALF = 4'b1100;
    localparam logic [3:0] SEL_LO_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    localparam logic        RstEnable    = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        WriteEnable  = 1'b1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic is_load_op(input logic [MEM_OP_W-1:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [MEM_OP_W-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and replicated store data for the
// incoming op, and big-endian lane extraction with extension for the pending load.
module mem_align
    import mem_ls_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op_i,
    input  logic [1:0]          lane_i,
    input  logic [31:0]         st_data_i,
    input  logic [MEM_OP_W-1:0] ld_op_i,
    input  logic [1:0]          ld_lane_i,
    input  logic [31:0]         rdata_i,
    output logic                is_load_o,
    output logic                is_store_o,
    output logic                misalign_o,
    output logic [3:0]          sel_o,
    output logic [31:0]         st_wdata_o,
    output logic [31:0]         ld_data_o
);

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi_addr);
        return hi_addr ? w[15:0] : w[31:16];
    endfunction

    function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
        return 32'(b);
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
        return 32'(h);
    endfunction

    always_comb begin
        is_load_o  = is_load_op(op_i);
        is_store_o = is_store_op(op_i);
        misalign_o = 1'b0;
        sel_o      = SEL_NONE;
        st_wdata_o = ZeroWord;
        case (op_i)
            OP_LB, OP_LBU, OP_SB: begin
                sel_o      = SEL_LANE0 >> lane_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel_o      = lane_i[1] ? SEL_LO_HALF : SEL_HI_HALF;
                st_wdata_o = {2{st_data_i[15:0]}};
                misalign_o = lane_i[0];
            end
            OP_LW, OP_SW: begin
                sel_o      = SEL_WORD;
                st_wdata_o = st_data_i;
                misalign_o = |lane_i;
            end
            default: ;
        endcase

        ld_data_o = ZeroWord;
        case (ld_op_i)
            OP_LB:   ld_data_o = sext8(pick_byte(rdata_i, ld_lane_i));
            OP_LBU:  ld_data_o = {24'h0, pick_byte(rdata_i, ld_lane_i)};
            OP_LH:   ld_data_o = sext16(pick_half(rdata_i, ld_lane_i[1]));
            OP_LHU:  ld_data_o = {16'h0, pick_half(rdata_i, ld_lane_i[1])};
            OP_LW:   ld_data_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ls.sv
// Load/store MEM stage: issues one RAM access at a time over req/ack, stalls
// the pipeline while it is outstanding, and aborts after WAIT_MAX wait cycles.
module mem_ls
    import mem_ls_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [MEM_OP_W-1:0]   memop_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           st_data_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stall_req_o,
    output logic                  misalign_o,
    output logic                  timeout_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [3:0]            ram_sel_o,
    output logic [31:0]           ram_wdata_o,
    input  logic                  ram_ack_i,
    input  logic [31:0]           ram_rdata_i
);

    localparam int                CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [MEM_OP_W-1:0]     req_op_p1;
    logic [1:0]              req_lane_p1;
    logic [REG_ADDR_W-1:0]   req_wd_p1;

    logic        is_load, is_store, misalign, mem_op;
    logic [3:0]  sel;
    logic [31:0] st_wdata, ld_data;
    logic        accept, mis_hit, ack_hit, abort, stall;

    mem_align u_align (
        .op_i       (memop_i),
        .lane_i     (mem_addr_i[1:0]),
        .st_data_i  (st_data_i),
        .ld_op_i    (req_op_p1),
        .ld_lane_i  (req_lane_p1),
        .rdata_i    (ram_rdata_i),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .misalign_o (misalign),
        .sel_o      (sel),
        .st_wdata_o (st_wdata),
        .ld_data_o  (ld_data)
    );

    assign mem_op      = is_load | is_store;
    assign stall_req_o = stall & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) state_q <= S_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        mis_hit = 1'b0;
        ack_hit = 1'b0;
        abort   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && mem_op) begin
                    if (misalign) begin
                        mis_hit = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The ack wins over the abort when both land on the last wait cycle.
                if (ram_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request registers, RAM port and WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt_q       <= '0;
            req_op_p1   <= OP_NOP;
            req_lane_p1 <= 2'b00;
            req_wd_p1   <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_sel_o   <= SEL_NONE;
            ram_wdata_o <= ZeroWord;
            wd_o        <= REG_ADDR_W'(NOPRegAddr);
            wreg_o      <= WriteDisable;
            wdata_o     <= ZeroWord;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            misalign_o <= mis_hit;
            timeout_o  <= abort;
            wd_o       <= REG_ADDR_W'(NOPRegAddr);
            wreg_o     <= WriteDisable;
            wdata_o    <= ZeroWord;
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                if (accept) begin
                    req_op_p1   <= memop_i;
                    req_lane_p1 <= mem_addr_i[1:0];
                    req_wd_p1   <= wd_i;
                    ram_req_o   <= 1'b1;
                    ram_we_o    <= is_store;
                    ram_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                    ram_sel_o   <= sel;
                    ram_wdata_o <= st_wdata;
                end else if (valid_i && !mem_op) begin
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (ack_hit || abort) ram_req_o <= 1'b0;
                if (ack_hit && is_load_op(req_op_p1)) begin
                    wd_o    <= req_wd_p1;
                    wreg_o  <= WriteEnable;
                    wdata_o <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ls.sv
// Randomized bench for mem_ls: a transaction-level model predicts byte enables,
// store data, load results, stall and abort behaviour for each issued op.
module tb_mem_ls;

    localparam int WMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  memop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [31:0] st_data_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o, misalign_o, timeout_o;
    logic        ram_req_o, ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_ls #(.ADDR_W(32), .REG_ADDR_W(5), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i), .wd_i(wd_i),
        .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .st_data_i(st_data_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o), .ram_req_o(ram_req_o),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
        .ram_wdata_o(ram_wdata_o), .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, 0 for anything that is not a memory op.
    function automatic int m_size(input int op);
        case (op)
            1, 2, 6: return 1;
            3, 4, 7: return 2;
            5, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input int op, input logic [31:0] a);
        int s = m_size(op);
        if (s == 1) return 4'b1000 >> a[1:0];
        if (s == 2) return a[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] st);
        int s = m_size(op);
        if (s == 1) return (st & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (st & 32'hFFFF) * 32'h0001_0001;
        return st;
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
        h = (rd >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            2:       return b;
            3:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4:       return h;
            default: return rd;
        endcase
    endfunction

    task automatic idle_cycle();
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk_eq("idle_wreg", wreg_o, 0);
        chk_eq("idle_wd", wd_o, 0);
        chk_eq("idle_wdata", wdata_o, 0);
    endtask

    // ack_n: WAIT cycle (1-based) on which the RAM acks; beyond WMAX+1 means never.
    task automatic do_op(input int op, input int ack_n, input logic [31:0] addr,
                         input logic [31:0] st, input logic [31:0] rdata,
                         input logic [31:0] wdat, input logic [4:0] wd, input logic wr);
        int  sz;
        bit  is_mem, mis, done;
        sz     = m_size(op);
        is_mem = (sz != 0);
        mis    = is_mem && ((int'(addr[1:0]) % sz) != 0);
        valid_i = 1'b1; memop_i = op[3:0]; mem_addr_i = addr; st_data_i = st;
        wdata_i = wdat; wd_i = wd; wreg_i = wr;
        ram_ack_i = 1'($urandom_range(0, 1));
        ram_rdata_i = $urandom;
        #1;
        chk_eq("stall_issue", stall_req_o, 32'(is_mem && !mis));
        @(posedge clk); #1;
        valid_i = 1'b0;
        ram_ack_i = 1'b0;
        if (!is_mem) begin
            chk_eq("alu_wd", wd_o, wd);
            chk_eq("alu_wreg", wreg_o, wr);
            chk_eq("alu_wdata", wdata_o, wdat);
            chk_eq("alu_misalign", misalign_o, 0);
            chk_eq("alu_timeout", timeout_o, 0);
        end else if (mis) begin
            chk_eq("mis_pulse", misalign_o, 1);
            chk_eq("mis_wreg", wreg_o, 0);
            chk_eq("mis_req", ram_req_o, 0);
            @(posedge clk); #1;
            chk_eq("mis_pulse_end", misalign_o, 0);
            chk_eq("mis_req_after", ram_req_o, 0);
        end else begin
            chk_eq("acc_wreg", wreg_o, 0);
            chk_eq("acc_addr", ram_addr_o, addr & 32'hFFFF_FFFC);
            chk_eq("acc_sel", ram_sel_o, m_sel(op, addr));
            chk_eq("acc_we", ram_we_o, 32'(op >= 6));
            if (op >= 6) chk_eq("acc_wdata", ram_wdata_o, m_wdata(op, st));
            done = 0;
            for (int n = 1; n <= WMAX + 1 && !done; n++) begin
                valid_i = 1'($urandom_range(0, 1)); memop_i = 4'($urandom);
                mem_addr_i = $urandom; wd_i = 5'($urandom);
                chk_eq("wait_req", ram_req_o, 1);
                chk_eq("wait_sel", ram_sel_o, m_sel(op, addr));
                if (n == ack_n) begin
                    ram_ack_i = 1'b1; ram_rdata_i = rdata;
                    #1;
                    chk_eq("ack_stall", stall_req_o, 0);
                    @(posedge clk); #1;
                    ram_ack_i = 1'b0; ram_rdata_i = $urandom;
                    chk_eq("ack_req_drop", ram_req_o, 0);
                    chk_eq("ack_wreg", wreg_o, 32'(op <= 5));
                    if (op <= 5) begin
                        chk_eq("ld_wd", wd_o, wd);
                        chk_eq("ld_data", wdata_o, m_load(op, addr, rdata));
                    end
                    chk_eq("ack_timeout", timeout_o, 0);
                    done = 1;
                end else if (n == WMAX + 1) begin
                    #1;
                    chk_eq("abort_stall", stall_req_o, 0);
                    @(posedge clk); #1;
                    chk_eq("abort_timeout", timeout_o, 1);
                    chk_eq("abort_req", ram_req_o, 0);
                    chk_eq("abort_wreg", wreg_o, 0);
                    done = 1;
                end else begin
                    #1;
                    chk_eq("wait_stall", stall_req_o, 1);
                    @(posedge clk); #1;
                end
            end
            valid_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; memop_i = 4'd0; wd_i = 5'd0; wreg_i = 1'b0;
        wdata_i = 32'h0; mem_addr_i = 32'h0; st_data_i = 32'h0;
        ram_ack_i = 1'b0; ram_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req", ram_req_o, 0);
        chk_eq("rst_wreg", wreg_o, 0);
        chk_eq("rst_wdata", wdata_o, 0);
        chk_eq("rst_stall", stall_req_o, 0);
        chk_eq("rst_sel", ram_sel_o, 0);
        @(negedge clk);
        rst = 1'b0;

        idle_cycle();
        do_op(0, 0, 32'h0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1);
        do_op(12, 0, 32'h8, 32'h0, 32'h0, 32'hCAFE_0001, 5'd9, 1'b1);
        do_op(1, 1, 32'h101, 32'h0, 32'h0080_FF00, 32'h0, 5'd7, 1'b1);
        do_op(2, 1, 32'h101, 32'h0, 32'h0080_FF00, 32'h0, 5'd7, 1'b1);
        do_op(7, 3, 32'h202, 32'hABCD_1234, 32'h0, 32'h0, 5'd1, 1'b0);
        do_op(5, 1, 32'h3, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
        do_op(5, 99, 32'h400, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
        do_op(3, WMAX + 1, 32'h502, 32'h0, 32'h8001_7FFE, 32'h0, 5'd5, 1'b1);
        do_op(4, 2, 32'h500, 32'h0, 32'h8001_7FFE, 32'h0, 5'd6, 1'b1);
        do_op(6, 1, 32'h603, 32'h0000_00A5, 32'h0, 32'h0, 5'd0, 1'b0);
        idle_cycle();

        for (int i = 0; i < 300; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(1, WMAX + 2)),
                  $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
        end

        // Reset in the middle of an outstanding access
        valid_i = 1'b1; memop_i = 4'd5; mem_addr_i = 32'h700; wd_i = 5'd2; wreg_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_eq("midrst_req", ram_req_o, 0);
        chk_eq("midrst_stall", stall_req_o, 0);
        chk_eq("midrst_we", ram_we_o, 0);
        chk_eq("midrst_addr", ram_addr_o, 0);
        chk_eq("midrst_sel", ram_sel_o, 0);
        chk_eq("midrst_wdata", ram_wdata_o, 0);
        chk_eq("midrst_wd", wd_o, 0);
        chk_eq("midrst_wreg", wreg_o, 0);
        chk_eq("midrst_misalign", misalign_o, 0);
        chk_eq("midrst_timeout", timeout_o, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 0, 32'h0, 32'h0, 32'h0, 32'h5A5A_0F0F, 5'd17, 1'b1);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
